// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: a - b - bin over WIDTH cycles.
// Start/ready/done handshake with registered borrow, overflow and zero flags.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             brw_next;
    logic             d;
    logic             x;
    logic             y;
    logic             last;

    // One full-subtractor cell on the current LSBs plus the shifted result
    always_comb begin
        x        = a_reg[0];
        y        = b_reg[0];
        d        = x ^ y ^ brw;
        brw_next = (~x & y) | (~(x ^ y) & brw);
        res_next = {d, res[WIDTH-1:1]};
        last     = (cnt == LAST);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ready = (state == IDLE);

    // Operand shifting, borrow chain and result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            res   <= '0;
            cnt   <= '0;
            brw   <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                a_reg <= a;
                b_reg <= b;
                brw   <= bin;
                cnt   <= '0;
                res   <= '0;
            end else if (state == SHIFT) begin
                res   <= res_next;
                a_reg <= a_reg >> 1;
                b_reg <= b_reg >> 1;
                brw   <= brw_next;
                if (!last) begin
                    cnt <= cnt + CW'(1);
                end else begin
                    diff <= res_next;
                    bout <= brw_next;
                    ovf  <= brw ^ brw_next;
                    zero <= (res_next == '0);
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor at WIDTH=8 and WIDTH=16.
// Arithmetic reference model plus per-cycle handshake model.
module tb_serial_subtractor;

    typedef struct packed {
        logic [15:0] d;
        logic        bo;
        logic        ov;
        logic        z;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start8, start16;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        bin8, bin16;
    logic        ready8, done8, bout8, ovf8, zero8;
    logic        ready16, done16, bout16, ovf16, zero16;
    logic [7:0]  diff8;
    logic [15:0] diff16;

    int   cmp_n = 0;
    int   err_n = 0;
    bit   live = 1'b0;
    int   cyc = 0;
    int   dt[$];
    int   m8_cnt = 0;
    int   m16_cnt = 0;
    res_t q8[$];
    res_t q16[$];
    res_t e8 = '0;
    res_t e16 = '0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8),
        .a(a8), .b(b8), .bin(bin8),
        .ready(ready8), .done(done8), .diff(diff8),
        .bout(bout8), .ovf(ovf8), .zero(zero8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16),
        .a(a16), .b(b16), .bin(bin16),
        .ready(ready16), .done(done16), .diff(diff16),
        .bout(bout16), .ovf(ovf16), .zero(zero16)
    );

    function automatic res_t ref_sub(int w, longint a, longint b, bit bi);
        res_t   r;
        longint lim;
        longint full;
        longint sa;
        longint sb;
        longint s;
        lim  = longint'(1) << (w - 1);
        full = a - b - longint'(bi);
        r    = '0;
        r.bo = (full < 0);
        r.d  = 16'(full & ((lim << 1) - 1));
        sa   = (a >= lim) ? a - 2 * lim : a;
        sb   = (b >= lim) ? b - 2 * lim : b;
        s    = sa - sb - longint'(bi);
        r.ov = (s < -lim) || (s >= lim);
        r.z  = (r.d == 16'd0);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level timing model: busy for WIDTH+1 edges after accept
    always @(posedge clk) begin
        if (!rst_n) begin
            m8_cnt = 0;
            q8.delete();
            e8 = '0;
        end else if (m8_cnt == 0) begin
            if (start8) begin
                q8.push_back(ref_sub(8, longint'(a8), longint'(b8), bin8));
                m8_cnt = 9;
            end
        end else begin
            m8_cnt--;
            if (m8_cnt == 1) e8 = q8.pop_front();
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m16_cnt = 0;
            q16.delete();
            e16 = '0;
        end else if (m16_cnt == 0) begin
            if (start16) begin
                q16.push_back(ref_sub(16, longint'(a16), longint'(b16), bin16));
                m16_cnt = 17;
            end
        end else begin
            m16_cnt--;
            if (m16_cnt == 1) e16 = q16.pop_front();
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (live) begin
            cyc++;
            chk("ready8", 32'(ready8), 32'(m8_cnt == 0));
            chk("done8", 32'(done8), 32'(m8_cnt == 1));
            chk("res8", {diff8, bout8, ovf8, zero8}, {e8.d[7:0], e8.bo, e8.ov, e8.z});
            chk("ready16", 32'(ready16), 32'(m16_cnt == 0));
            chk("done16", 32'(done16), 32'(m16_cnt == 1));
            chk("res16", {diff16, bout16, ovf16, zero16}, {e16.d, e16.bo, e16.ov, e16.z});
            if (done8) dt.push_back(cyc);
        end
    end

    task automatic wait_ready8();
        int n = 0;
        while (!ready8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready8) chk("ready8_timeout", 32'(ready8), 32'd1);
    endtask

    task automatic wait_ready16();
        int n = 0;
        while (!ready16 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready16) chk("ready16_timeout", 32'(ready16), 32'd1);
    endtask

    task automatic op8(input string nm, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tbin, input logic [7:0] ed, input logic eb,
                       input logic eo, input logic ez);
        int n;
        wait_ready8();
        a8 = ta;
        b8 = tb;
        bin8 = tbin;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'h00;
        b8 = 8'h00;
        n = 0;
        while (!done8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_lat"}, 32'(n), 32'd8);
        chk(nm, {diff8, bout8, ovf8, zero8}, {ed, eb, eo, ez});
    endtask

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0;
        start16 = 1'b0;
        a8 = '0; b8 = '0; bin8 = 1'b0;
        a16 = '0; b16 = '0; bin16 = 1'b0;
        repeat (2) @(negedge clk);
        live = 1'b1;
        chk("rst_ready", 32'(ready8), 32'd1);
        chk("rst_out", {diff8, bout8, ovf8, zero8, done8}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        op8("sub_100_50", 8'd100, 8'd50, 1'b0, 8'd50, 1'b0, 1'b0, 1'b0);
        op8("sub_50_100", 8'd50, 8'd100, 1'b0, 8'd206, 1'b1, 1'b0, 1'b0);
        op8("sub_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
        op8("sub_200_100_b", 8'd200, 8'd100, 1'b1, 8'd99, 1'b0, 1'b1, 1'b0);
        op8("sub_5_5", 8'h05, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        op8("sub_0_0_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        op8("sub_7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);

        wait_ready8();
        dt.delete();
        start8 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            bin8 = 1'($urandom);
            @(negedge clk);
        end
        start8 = 1'b0;
        repeat (12) @(negedge clk);
        chk("b2b_count", 32'(dt.size()), 32'd4);
        chk("b2b_gap1", 32'(dt[1] - dt[0]), 32'd10);
        chk("b2b_gap2", 32'(dt[2] - dt[1]), 32'd10);

        wait_ready8();
        a8 = 8'h33;
        b8 = 8'h11;
        bin8 = 1'b0;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_ready", 32'(ready8), 32'd1);
        chk("abort_out", {diff8, bout8, ovf8, zero8, done8}, 32'd0);
        repeat (10) @(negedge clk);
        op8("sub_ff_ff", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    wait_ready8();
                    a8 = 8'($urandom);
                    b8 = 8'($urandom);
                    bin8 = 1'($urandom);
                    start8 = 1'b1;
                    @(negedge clk);
                    start8 = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            begin
                for (int j = 0; j < 1000; j++) begin
                    wait_ready16();
                    a16 = 16'($urandom);
                    b16 = 16'($urandom);
                    bin16 = 1'($urandom);
                    start16 = 1'b1;
                    @(negedge clk);
                    start16 = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
        join
        repeat (25) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, LSB-first subtractor computing `a - b - bin` over WIDTH clock cycles, with a start/ready/done handshake. It is the inverse-operation companion to the team's adder blocks and shares their operand conventions: WIDTH-bit operands, a single-bit borrow in place of carry, and a borrow-out in place of carry-out. It trades latency for one full-subtractor cell, and adds registered signed-overflow and zero flags.

## Interface
- WIDTH, 8, operand/result width in bits; must be ≥ 2.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only while `ready`=1.
- a  in  WIDTH  minuend, unsigned or two's complement.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow-in.
- ready  out  1  high iff FSM in IDLE; decoded from state.
- done  out  1  one-cycle pulse; results valid while high.
- diff  out  WIDTH  `(a - b - bin) mod 2^WIDTH`, registered.
- bout  out  1  borrow-out; 1 iff `a < b + bin` (unsigned).
- ovf  out  1  signed overflow of `a - b - bin`.
- zero  out  1  1 iff `diff` == 0.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE → SHIFT when `start`=1 at an edge.
  - At that edge, latch `a`, `b` into shift registers.
  - Set the borrow flop to `bin`.
  - Clear the bit counter and the result shift register.
- SHIFT, one bit per edge, with `x` = LSB of the `a` register and `y` = LSB of the `b` register:
  - `d` = `x ^ y ^ brw`.
  - `brw_next` = `(~x & y) | (~(x ^ y) & brw)`.
  - Shift the result register right, inserting `d` at the MSB.
  - Shift the `a` and `b` registers right.
  - Increment the counter.
- SHIFT → DONE on the edge that processes bit WIDTH-1 (counter = WIDTH-1). On that same edge:
  - `diff` ← final result.
  - `bout` ← `brw_next`.
  - `ovf` ← `brw ^ brw_next`, i.e. the borrow into the MSB xor the borrow out of the MSB.
  - `zero` ← (final result == 0).
  - `done` ← 1.
- DONE → IDLE unconditionally on the next edge; `done` ← 0.
- `diff`, `bout`, `ovf` and `zero` hold their values until the next DONE entry or reset.
- `start` in SHIFT or DONE is ignored; input operands are not sampled.
- `start` held high continuously produces back-to-back operations, each re-sampling `a`/`b`/`bin` at its accept edge.
- Counter width is `$clog2(WIDTH)`. The counter never wraps mid-operation; it is cleared on accept.

## Timing
- Accept edge E0: IDLE with `start`=1.
- `ready`=0 from just after E0 until just after E(WIDTH+1).
- Bits 0..WIDTH-1 are processed on E1..E(WIDTH).
- `done`=1 for exactly one cycle, between E(WIDTH) and E(WIDTH+1). Latency is WIDTH edges from accept to `done`.
- Earliest next accept is E(WIDTH+2). Throughput is one operation per WIDTH+2 cycles.
- Reset behaviour, at any edge with `rst_n`=0:
  - state ← IDLE.
  - `diff` ← 0, `bout` ← 0, `ovf` ← 0, `zero` ← 0, `done` ← 0.
  - Internal registers are cleared.
  - `ready` reads 1 after the first reset edge.
- Reset during SHIFT or DONE aborts the operation. No `done` pulse is produced, and the previous results are lost.
- Reset has priority over `start` on the same edge.

## Test plan
- WIDTH=8, `a`=100, `b`=50, `bin`=0:
  - Required: `diff`=50, `bout`=0, `ovf`=0, `zero`=0.
  - `done` high exactly 8 edges after accept; `ready` low for 9 cycles.
- `a`=50, `b`=100, `bin`=0: `diff`=206, `bout`=1, `ovf`=0.
- Signed and borrow-in cases:
  - `a`=0x80, `b`=0x01, `bin`=0 → `diff`=0x7F, `ovf`=1, `bout`=0.
  - `a`=200, `b`=100, `bin`=1 → `diff`=99, `bout`=0.
  - `a`=0x05, `b`=0x05 → `diff`=0, `zero`=1.
- Handshake:
  - Hold `start`=1 with operands changing each cycle. Check that only the values present at the accept edges are used.
  - Check that consecutive `done` pulses are exactly 10 cycles apart.
- Reset mid-operation:
  - Drive `rst_n`=0 for one edge, 3 cycles into SHIFT.
  - Required: no `done`; all outputs 0; `ready`=1.
  - A following 0xFF − 0xFF operation gives `diff`=0, `zero`=1.
- Randomized, against a reference model of `a - b - bin`:
  - 1000 random operations at WIDTH=8 and at WIDTH=16.
  - Compare `diff`, `bout`, `ovf` and `zero` on every `done`.
